// File: rtl/instr_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit_pkg
//   Shared definitions for the instruction fetch unit and its consumers.
//   Contents:
//     OPC_*          RV32 major opcode constants seen on the opcode output
//     NOP_INSN       canonical NOP (addi x0,x0,0), loaded into instr on reset
//     fetch_state_e  fetch FSM state encoding
//     align_word     clears address bits [1:0] of a redirect target
// ----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

    localparam logic [6:0]  OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,  // issue a read request at pc
        ST_WAIT  = 2'd1,  // request outstanding, waiting for rvalid
        ST_HOLD  = 2'd2   // captured instruction parked until the decoder takes it
    } fetch_state_e;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//   Single-outstanding-request instruction fetch stage. Issues one read per
//   instruction, registers the returned word together with its address, and
//   parks it while the decoder stalls. Redirects from execute either steer
//   the next request or, when a read is in flight, mark its data for discard.
//
//   Ports
//     clk            rising-edge clock
//     reset          synchronous active-high reset
//     imem_req       read request pulse (one cycle per request)
//     imem_addr      read address (= pc), meaningful while imem_req=1
//     imem_rvalid    read data valid pulse
//     imem_rdata     read data, valid with imem_rvalid
//     branch_taken   redirect request
//     branch_target  redirect address (bits [1:0] ignored)
//     stall          decoder cannot accept the presented instruction
//     instr_valid    instr / instr_pc hold a live instruction
//     instr          registered instruction word
//     instr_pc       registered address of instr
//     opcode         instr[6:0]
// ----------------------------------------------------------------------------
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [6:0]  opcode
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         squash_q, squash_d;
    logic         instr_valid_q, instr_valid_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic [31:0]  target_aligned;

    assign target_aligned = align_word(branch_target);

    // A redirect in FETCH suppresses the request so the stale pc never goes out.
    assign imem_req  = (state_q == ST_FETCH) && !branch_taken;
    assign imem_addr = pc_q;

    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign opcode      = instr_q[6:0];

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        squash_d      = squash_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;

        case (state_q)
            ST_FETCH: begin
                if (branch_taken) begin
                    pc_d          = target_aligned;
                    instr_valid_d = 1'b0;
                end else begin
                    state_d = ST_WAIT;
                    // A live instruction presented with stall=0 is consumed now.
                    if (!stall) instr_valid_d = 1'b0;
                end
            end

            ST_WAIT: begin
                if (imem_rvalid) begin
                    state_d = ST_FETCH;
                    if (squash_q || branch_taken) begin
                        squash_d      = 1'b0;
                        instr_valid_d = 1'b0;
                        if (branch_taken) pc_d = target_aligned;
                    end else begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + 32'd4;
                        if (stall) state_d = ST_HOLD;
                    end
                end else if (branch_taken) begin
                    // pc already points at the new target; the in-flight word
                    // is dropped on arrival. Later redirects simply overwrite pc.
                    squash_d      = 1'b1;
                    pc_d          = target_aligned;
                    instr_valid_d = 1'b0;
                end else if (!stall) begin
                    instr_valid_d = 1'b0;
                end
            end

            ST_HOLD: begin
                if (branch_taken) begin
                    instr_valid_d = 1'b0;
                    pc_d          = target_aligned;
                    state_d       = ST_FETCH;
                end else if (!stall) begin
                    instr_valid_d = 1'b0;
                    state_d       = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            squash_q      <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= NOP_INSN;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            squash_q      <= squash_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit: a latency-programmable memory
//   responder, a transaction-level reference model checked every cycle, and
//   hand-computed literal expectations at key points of the script.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .stall        (stall),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .opcode       (opcode)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- memory contents ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0033;
            32'h0000_0004: return 32'h0000_2003;
            32'h0000_0008: return 32'hDEAD_BEEF;
            32'hFFFF_FFFC: return 32'h0000_0063;
            default:       return a ^ 32'h1357_9BDF;
        endcase
    endfunction

    // ---------------- memory responder ----------------
    int          lat = 1;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;

    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
    end

    always @(posedge clk) begin
        logic        req_s;
        logic [31:0] addr_s;
        logic        rst_s;
        req_s  = imem_req;
        addr_s = imem_addr;
        rst_s  = reset;
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (rst_s) begin
            pend = 1'b0;
        end else begin
            if (req_s) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = addr_s;
            end
            if (pend) begin
                if (cnt <= 1) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(paddr);
                    pend        = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // Tracks transactions: whether a read is in flight, whether its data must
    // be dropped, and whether a captured instruction is parked on the decoder.
    logic        m_inflight, m_drop, m_parked, m_valid;
    logic [31:0] m_pc, m_instr, m_ipc;

    always @(posedge clk) begin
        if (reset) begin
            m_inflight = 1'b0;
            m_drop     = 1'b0;
            m_parked   = 1'b0;
            m_valid    = 1'b0;
            m_pc       = 32'h0000_0000;
            m_instr    = 32'h0000_0013;
            m_ipc      = 32'h0;
        end else if (m_parked) begin
            if (branch_taken || !stall) begin
                m_parked = 1'b0;
                m_valid  = 1'b0;
                if (branch_taken) m_pc = branch_target & 32'hFFFF_FFFC;
            end
        end else if (!m_inflight) begin
            if (branch_taken) begin
                m_pc    = branch_target & 32'hFFFF_FFFC;
                m_valid = 1'b0;
            end else begin
                m_inflight = 1'b1;
                if (!stall) m_valid = 1'b0;
            end
        end else if (imem_rvalid) begin
            m_inflight = 1'b0;
            if (m_drop || branch_taken) begin
                m_drop  = 1'b0;
                m_valid = 1'b0;
                if (branch_taken) m_pc = branch_target & 32'hFFFF_FFFC;
            end else begin
                m_instr  = imem_rdata;
                m_ipc    = m_pc;
                m_valid  = 1'b1;
                m_pc     = m_pc + 32'd4;
                m_parked = stall;
            end
        end else if (branch_taken) begin
            m_drop  = 1'b1;
            m_pc    = branch_target & 32'hFFFF_FFFC;
            m_valid = 1'b0;
        end else if (!stall) begin
            m_valid = 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic chk_en = 1'b0;

    always @(negedge clk) begin
        logic exp_req;
        if (chk_en) begin
            exp_req = !m_inflight && !m_parked && !branch_taken;
            check("model_req", imem_req, exp_req);
            if (exp_req) check("model_addr", imem_addr, m_pc);
            check("model_valid", instr_valid, m_valid);
            check("model_instr", instr, m_instr);
            check("model_instr_pc", instr_pc, m_ipc);
            check("model_opcode", opcode, m_instr[6:0]);
        end
    end

    // ---------------- directed script ----------------
    task automatic nc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        branch_taken  = 1'b0;
        branch_target = '0;
        stall         = 1'b0;

        nc(); chk_en = 1'b1;
        nc();
        mid();
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_instr_pc", instr_pc, 32'h0);

        // cycle 1: first request at RESET_PC
        nc(); reset = 1'b0;
        mid();
        check("c1_req", imem_req, 1'b1);
        check("c1_addr", imem_addr, 32'h0);
        nc();                                   // cycle 2: WAIT, data returns
        mid();
        check("c2_req", imem_req, 1'b0);
        nc();                                   // cycle 3: instruction live
        mid();
        check("c3_valid", instr_valid, 1'b1);
        check("c3_opcode", opcode, 7'b0110011);
        check("c3_instr_pc", instr_pc, 32'h0);
        check("c3_addr", imem_addr, 32'h4);

        // stall while the load at address 4 is held
        nc(); stall = 1'b1;                     // cycle 4: capture with stall
        nc();                                   // cycle 5
        for (int i = 0; i < 3; i++) begin
            mid();
            check("hold_valid", instr_valid, 1'b1);
            check("hold_instr", instr, 32'h0000_2003);
            check("hold_instr_pc", instr_pc, 32'h4);
            check("hold_req", imem_req, 1'b0);
            nc();
        end
        stall = 1'b0;                           // cycle 8: accepted
        mid();
        nc();                                   // cycle 9
        lat = 3;
        mid();
        check("release_req", imem_req, 1'b1);
        check("release_addr", imem_addr, 32'h8);

        // redirect while waiting; late data must be dropped
        nc(); branch_taken = 1'b1; branch_target = 32'h0000_0102;   // cycle 10
        mid();
        check("c10_req", imem_req, 1'b0);
        nc(); branch_taken = 1'b0;              // cycle 11
        mid();
        nc();                                   // cycle 12: rvalid DEADBEEF
        mid();
        check("squash_valid", instr_valid, 1'b0);
        nc(); lat = 2;                          // cycle 13
        mid();
        check("squash_addr", imem_addr, 32'h0000_0100);
        check("squash_req", imem_req, 1'b1);

        // second redirect replaces target, coincident with rvalid
        nc(); branch_taken = 1'b1; branch_target = 32'h0000_0200;   // cycle 14
        mid();
        nc(); branch_target = 32'h0000_0304;    // cycle 15: rvalid + branch
        mid();
        nc(); branch_taken = 1'b0; lat = 1;     // cycle 16
        mid();
        check("replace_addr", imem_addr, 32'h0000_0304);
        nc(); branch_taken = 1'b1; branch_target = 32'h0000_040B;   // cycle 17
        mid();
        nc(); branch_taken = 1'b0; lat = 3;     // cycle 18
        mid();
        check("coincident_addr", imem_addr, 32'h0000_0408);
        check("coincident_valid", instr_valid, 1'b0);

        // two redirects during one wait: latest wins
        nc(); branch_taken = 1'b1; branch_target = 32'h0000_0500;   // cycle 19
        mid();
        nc(); branch_target = 32'h0000_0600;    // cycle 20
        mid();
        nc(); branch_taken = 1'b0;              // cycle 21: rvalid dropped
        mid();
        nc();                                   // cycle 22
        mid();
        check("latest_addr", imem_addr, 32'h0000_0600);

        // redirect in FETCH to the top word, then wrap
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF; lat = 1;
        mid();
        check("fetch_branch_req", imem_req, 1'b0);
        nc(); branch_taken = 1'b0;              // cycle 23
        mid();
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        nc();                                   // cycle 24
        mid();
        nc(); lat = 3;                          // cycle 25
        mid();
        check("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
        check("wrap_opcode", opcode, 7'b1100011);
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_req", imem_req, 1'b1);

        // reset during WAIT
        nc(); reset = 1'b1;                     // cycle 26
        mid();
        nc(); reset = 1'b0; lat = 1;            // cycle 27
        mid();
        check("rstw_valid", instr_valid, 1'b0);
        check("rstw_instr", instr, 32'h0000_0013);
        check("rstw_req", imem_req, 1'b1);
        check("rstw_addr", imem_addr, 32'h0);

        // reset during HOLD
        nc(); stall = 1'b1;                     // cycle 28: capture with stall
        mid();
        nc(); reset = 1'b1;                     // cycle 29: HOLD
        mid();
        check("rsth_pre_valid", instr_valid, 1'b1);
        nc(); reset = 1'b0; stall = 1'b0;       // cycle 30
        mid();
        check("rsth_valid", instr_valid, 1'b0);
        check("rsth_instr", instr, 32'h0000_0013);
        check("rsth_addr", imem_addr, 32'h0);

        // branch overrides stall in HOLD
        nc(); stall = 1'b1;                     // cycle 31: capture
        mid();
        nc(); branch_taken = 1'b1; branch_target = 32'h0000_0044;   // cycle 32
        mid();
        check("hb_valid", instr_valid, 1'b1);
        nc(); branch_taken = 1'b0; stall = 1'b0;  // cycle 33
        mid();
        check("hb_after_valid", instr_valid, 1'b0);
        check("hb_addr", imem_addr, 32'h0000_0044);

        repeat (8) nc();
        chk_en = 1'b0;
        mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
